branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Parametrised conditional branch/jump unit that owns the program counter register.
- Accepts one branch request at a time: compare operands, condition code, signed/unsigned mode, two's-complement offset.
- Evaluates the branch in a registered stage, then redirects or advances the PC.
- Sits between instruction decode and instruction fetch. Replaces the separate fixed 16-bit less-than / greater-than / equal jump blocks with one generalised unit.

Parameters:
- WIDTH, 16, data/PC/offset width in bits
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of taken-branch statistics counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  freezes PC, FSM and handshake while high
- br_valid  input  1  branch request present
- br_ready  output  1  unit can accept a request
- br_cond  input  3  condition code
- br_signed  input  1  1 = signed compare, 0 = unsigned
- cmp_a  input  WIDTH  compare operand A
- cmp_b  input  WIDTH  compare operand B
- br_offset  input  WIDTH  two's-complement PC-relative offset
- pc  output  WIDTH  current program counter (registered)
- redirect  output  1  one-cycle pulse: pc was just resolved by a branch
- taken  output  1  one-cycle pulse, qualifies redirect: branch was taken
- taken_count  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (rst=1 at clock edge): pc=RESET_PC, state=IDLE, redirect=0, taken=0, taken_count=0. br_ready=0 while rst=1. Reset overrides stall and aborts an in-flight EVAL with no PC update.
- br_ready = (state==IDLE) && !rst && !stall (combinational).
- Accept occurs when br_valid && br_ready at a clock edge.
- Condition codes: 000 ALWAYS, 001 EQ, 010 NE, 011 LT (A<B), 100 GE, 101 GT, 110 LE, 111 NEVER. br_signed selects the LT/GE/GT/LE interpretation; EQ/NE ignore it.
- FSM states: IDLE, EVAL.
- IDLE, stall=0, no accept: pc <= pc+1, wrapping modulo 2^WIDTH.
- IDLE, accept:
  - Latch cmp_a, cmp_b, br_cond, br_signed, br_offset, and branch_pc = current pc.
  - pc holds; go to EVAL.
- EVAL, stall=1: hold everything.
- EVAL, stall=0: evaluate the latched condition, then go to IDLE.
  - Taken: pc <= branch_pc + br_offset (mod 2^WIDTH); taken <= 1.
  - Not taken: pc <= branch_pc + 1; taken <= 0.
  - In both cases redirect <= 1.
- redirect and taken are high for exactly one cycle, coincident with the new pc value. Otherwise both are 0. taken is never 1 without redirect.
- Offset 0 with taken: pc returns to branch_pc (self-loop). A zero offset is a legal target, not a "no jump" encoding.
- Latency: accept at edge N → resolved pc and redirect visible after edge N+1, plus any stall cycles spent in EVAL.
- taken_count increments on each taken resolution and saturates at 2^CNT_W-1. It is unaffected by not-taken branches.
- Operand inputs are don't-care outside the accept cycle. Latched values are used even if inputs change during EVAL.
- br_valid while not ready is held off; the requester keeps valid and payload stable until accept.
- Back-to-back: after resolution, br_ready returns high in the IDLE cycle that follows. Maximum throughput is one branch per 2 cycles.

Test Plan:
- Reset with RESET_PC=0x0010, rst high 2 cycles, then 3 free-run cycles → pc=0x0010 during reset, then 0x0011, 0x0012, 0x0013; redirect/taken/taken_count stay 0.
- pc=0x0020, accept LT signed, A=0xFFFF (-1), B=0x0001, offset=0x0008 → pc holds 0x0020 one cycle, then pc=0x0028 with redirect=1, taken=1; taken_count=1.
- Same operands with br_signed=0 → not taken: pc=0x0021, redirect=1, taken=0; taken_count unchanged.
- pc=0x0005, EQ A=B=0x1234, offset=0xFFFB (-5) → pc=0x0000; then offset=0 ALWAYS from 0x0000 → pc=0x0000 self-loop, taken=1.
- Accept GT, hold stall=1 for 3 cycles in EVAL, change cmp inputs meanwhile → pc frozen and br_ready=0; on stall release, resolution uses the latched operands.
- Assert rst during EVAL → pc=RESET_PC, no redirect pulse, state IDLE. Separately, CNT_W=2 with 5 taken branches → taken_count saturates at 3.

Source files
------------

// File: rtl/branch_unit.sv
// Conditional branch/jump unit that owns the program counter.
// A request is accepted in IDLE, evaluated from latched operands in EVAL, then the PC is redirected or advanced.
module branch_unit #(
  parameter int                 WIDTH    = 16,
  parameter logic [WIDTH-1:0]   RESET_PC = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic             br_signed,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  input  logic [WIDTH-1:0] br_offset,
  output logic [WIDTH-1:0] pc,
  output logic             redirect,
  output logic             taken,
  output logic [CNT_W-1:0] taken_count,
  output logic             state_dbg
);

  // Handshake: a request transfers on a rising edge where br_valid && br_ready;
  // the requester holds br_valid and payload stable until then. br_ready is
  // combinational and low during reset, stall, or while a branch is in EVAL.

  typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;

  localparam logic [2:0] C_ALWAYS = 3'b000;
  localparam logic [2:0] C_EQ     = 3'b001;
  localparam logic [2:0] C_NE     = 3'b010;
  localparam logic [2:0] C_LT     = 3'b011;
  localparam logic [2:0] C_GE     = 3'b100;
  localparam logic [2:0] C_GT     = 3'b101;
  localparam logic [2:0] C_LE     = 3'b110;
  localparam logic [2:0] C_NEVER  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic             accept, resolve, cond_true;
  logic             lt, eq;
  logic [WIDTH-1:0] lat_a, lat_b, lat_offset, branch_pc;
  logic [2:0]       lat_cond;
  logic             lat_signed;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EVAL;
      EVAL:    if (!stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    br_ready  = (state == IDLE) && !rst && !stall;
    accept    = br_valid && br_ready;
    resolve   = (state == EVAL) && !stall;
    state_dbg = (state == EVAL);
  end

  // Condition is evaluated only from the values captured at accept.
  always_comb begin
    eq = (lat_a == lat_b);
    if (lat_signed) lt = $signed(lat_a) < $signed(lat_b);
    else            lt = lat_a < lat_b;
    cond_true = 1'b0;
    case (lat_cond)
      C_ALWAYS: cond_true = 1'b1;
      C_EQ:     cond_true = eq;
      C_NE:     cond_true = !eq;
      C_LT:     cond_true = lt;
      C_GE:     cond_true = !lt;
      C_GT:     cond_true = !lt && !eq;
      C_LE:     cond_true = lt || eq;
      C_NEVER:  cond_true = 1'b0;
      default:  cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      redirect    <= 1'b0;
      taken       <= 1'b0;
      taken_count <= '0;
      lat_a       <= '0;
      lat_b       <= '0;
      lat_offset  <= '0;
      lat_cond    <= C_NEVER;
      lat_signed  <= 1'b0;
      branch_pc   <= RESET_PC;
    end else begin
      redirect <= 1'b0;
      taken    <= 1'b0;
      if (accept) begin
        lat_a      <= cmp_a;
        lat_b      <= cmp_b;
        lat_offset <= br_offset;
        lat_cond   <= br_cond;
        lat_signed <= br_signed;
        branch_pc  <= pc;
      end else if (state == IDLE && !stall) begin
        pc <= pc + 1'b1;
      end
      if (resolve) begin
        redirect <= 1'b1;
        taken    <= cond_true;
        // Zero offset is a real target (self-loop), not a "no jump" encoding.
        pc       <= cond_true ? branch_pc + lat_offset : branch_pc + 1'b1;
        if (cond_true && taken_count != CNT_MAX)
          taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: driver pushes expected {count, taken, pc} per branch,
// a negedge monitor pops and compares on every redirect pulse.
module tb_branch_unit;
  localparam int          W   = 16;
  localparam logic [15:0] RPC = 16'h0010;

  logic clk = 1'b0;
  logic rst, stall, br_valid, br_signed;
  logic [2:0]   br_cond;
  logic [W-1:0] cmp_a, cmp_b, br_offset;

  logic         br_ready, redirect, taken, state_dbg;
  logic [W-1:0] pc;
  logic [15:0]  taken_count;

  logic         s_ready, s_redirect, s_taken, s_state;
  logic [W-1:0] s_pc;
  logic [1:0]   s_count;

  logic [32:0]  exp_q[$];
  logic [W-1:0] mpc;
  logic [15:0]  mcnt;
  int checks = 0;
  int errors = 0;

  branch_unit #(.WIDTH(W), .RESET_PC(RPC), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_signed(br_signed), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .br_offset(br_offset), .pc(pc), .redirect(redirect), .taken(taken),
    .taken_count(taken_count), .state_dbg(state_dbg)
  );

  // Same stimulus, 2-bit counter, to exercise saturation.
  branch_unit #(.WIDTH(W), .RESET_PC(16'h0000), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_ready(s_ready),
    .br_cond(br_cond), .br_signed(br_signed), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .br_offset(br_offset), .pc(s_pc), .redirect(s_redirect), .taken(s_taken),
    .taken_count(s_count), .state_dbg(s_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      mpc = mpc + 16'd1;
      check("idle_pc", 32'(pc), 32'(mpc));
      check("idle_pulses", {30'd0, redirect, taken}, 32'd0);
      check("idle_count", 32'(taken_count), 32'(mcnt));
    end
  endtask

  task automatic issue(input logic [2:0] cond, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] off,
                       input logic exp_taken, input int stall_n);
    logic [W-1:0] target;
    check("ready_before_accept", 32'(br_ready), 32'd1);
    br_valid = 1'b1; br_cond = cond; br_signed = sgn;
    cmp_a = a; cmp_b = b; br_offset = off;
    target = exp_taken ? mpc + off : mpc + 16'd1;
    if (exp_taken) mcnt = mcnt + 16'd1;
    exp_q.push_back({mcnt, exp_taken, target});
    cyc();
    // Scramble the payload: the unit must use what it latched.
    br_valid = 1'b0; cmp_a = ~a; cmp_b = ~b; br_cond = ~cond; br_signed = ~sgn;
    br_offset = 16'h5555;
    check("accept_pc_hold", 32'(pc), 32'(mpc));
    check("accept_not_ready", 32'(br_ready), 32'd0);
    check("accept_state_eval", 32'(state_dbg), 32'd1);
    if (stall_n > 0) begin
      stall = 1'b1;
      for (int i = 0; i < stall_n; i++) begin
        cyc();
        check("stall_pc_frozen", 32'(pc), 32'(mpc));
        check("stall_not_ready", 32'(br_ready), 32'd0);
        check("stall_state_eval", 32'(state_dbg), 32'd1);
        check("stall_no_redirect", 32'(redirect), 32'd0);
      end
      stall = 1'b0;
    end
    cyc();
    mpc = target;
    check("resolve_ready_again", 32'(br_ready), 32'd1);
    check("resolve_state_idle", 32'(state_dbg), 32'd0);
  endtask

  // Monitor: every redirect must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [1:0]  sat;
    if (!rst) begin
      check("taken_implies_redirect", {31'd0, taken & ~redirect}, 32'd0);
      if (redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect: got pc %h expected no redirect", pc);
        end else begin
          e = exp_q.pop_front();
          sat = (e[32:17] > 16'd3) ? 2'd3 : e[18:17];
          check("redirect_pc", 32'(pc), 32'(e[15:0]));
          check("redirect_taken", 32'(taken), 32'(e[16]));
          check("taken_count", 32'(taken_count), 32'(e[32:17]));
          check("sat_count", 32'(s_count), 32'(sat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_cond = 3'd0; br_signed = 1'b0;
    cmp_a = '0; cmp_b = '0; br_offset = '0;
    mpc = RPC; mcnt = 16'd0;
    cyc();
    check("reset_pc", 32'(pc), 32'(RPC));
    check("reset_not_ready", 32'(br_ready), 32'd0);
    check("reset_pulses", {30'd0, redirect, taken}, 32'd0);
    check("reset_count", 32'(taken_count), 32'd0);
    cyc();
    check("reset_pc_2", 32'(pc), 32'(RPC));
    rst = 1'b0;
    idle(3);                                              // 0x11..0x13
    issue(3'd0, 1'b0, 16'h0000, 16'h0000, 16'h000D, 1'b1, 0);  // -> 0x0020
    issue(3'd3, 1'b1, 16'hFFFF, 16'h0001, 16'h0008, 1'b1, 0);  // LT signed -> 0x0028
    issue(3'd0, 1'b0, 16'h0000, 16'h0000, 16'hFFF8, 1'b1, 0);  // -> 0x0020
    issue(3'd3, 1'b0, 16'hFFFF, 16'h0001, 16'h0008, 1'b0, 0);  // LT unsigned -> 0x0021
    issue(3'd0, 1'b0, 16'h0000, 16'h0000, 16'hFFE4, 1'b1, 0);  // -> 0x0005
    issue(3'd1, 1'b0, 16'h1234, 16'h1234, 16'hFFFB, 1'b1, 0);  // EQ -> 0x0000
    issue(3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 0);  // self-loop 0x0000
    idle(2);                                              // 0x0002
    issue(3'd5, 1'b1, 16'h0005, 16'h0003, 16'h0010, 1'b1, 3);  // GT with stall -> 0x0012
    issue(3'd2, 1'b0, 16'h1234, 16'h1234, 16'h0040, 1'b0, 0);  // NE -> 0x0013
    issue(3'd4, 1'b0, 16'h8000, 16'h7FFF, 16'h0020, 1'b1, 0);  // GE unsigned -> 0x0033
    issue(3'd4, 1'b1, 16'h8000, 16'h7FFF, 16'h0020, 1'b0, 0);  // GE signed -> 0x0034
    issue(3'd6, 1'b1, 16'hFFFE, 16'hFFFE, 16'h0004, 1'b1, 0);  // LE signed eq -> 0x0038
    issue(3'd6, 1'b0, 16'h0002, 16'h0001, 16'h0004, 1'b0, 0);  // LE unsigned -> 0x0039
    issue(3'd5, 1'b0, 16'hFFFF, 16'h0001, 16'h0002, 1'b1, 0);  // GT unsigned -> 0x003B
    issue(3'd7, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b0, 0);  // NEVER -> 0x003C
    issue(3'd0, 1'b0, 16'h0000, 16'h0000, 16'hFFC2, 1'b1, 0);  // -> 0xFFFE
    idle(3);                                              // 0xFFFF, 0x0000 wrap, 0x0001
    check("pc_wrapped", 32'(pc), 32'h0000_0001);
    check("sat_count_final", 32'(s_count), 32'd3);

    // Reset lands while a branch sits in EVAL: no redirect, pc back to RESET_PC.
    check("ready_before_abort", 32'(br_ready), 32'd1);
    br_valid = 1'b1; br_cond = 3'd0; br_offset = 16'h0100;
    cyc();
    br_valid = 1'b0;
    check("abort_state_eval", 32'(state_dbg), 32'd1);
    rst = 1'b1;
    cyc();
    check("abort_pc", 32'(pc), 32'(RPC));
    check("abort_state_idle", 32'(state_dbg), 32'd0);
    check("abort_no_redirect", {30'd0, redirect, taken}, 32'd0);
    check("abort_count", 32'(taken_count), 32'd0);
    check("abort_sat_count", 32'(s_count), 32'd0);
    check("abort_not_ready", 32'(br_ready), 32'd0);
    rst = 1'b0;
    mpc = RPC; mcnt = 16'd0;
    idle(2);
    repeat (2) cyc();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
